// File: rtl/labfinalsoc_gravity_tick.sv
// -----------------------------------------------------------------------------
// labfinalsoc_gravity_tick
//
// Avalon-MM slave that turns the interval timer's interrupt line into game
// "gravity" drop events. Every rising edge of tick_irq is one base tick; while
// running, a drop event fires every P ticks, where P is the normal
// (LEVEL_PERIOD) or soft-drop (SOFT_PERIOD) period selected by CONTROL.soft.
// Each drop event produces a one-cycle drop_pulse for the game datapath and
// sets a sticky drop_pending flag that drives the CPU interrupt when enabled.
//
// Ports:
//   clk         sole clock
//   reset_n     asynchronous, active-low reset
//   address     register select (0 STATUS, 1 CONTROL, 2 LEVEL_PERIOD,
//               3 SOFT_PERIOD, 4 TICK_COUNT, 5 DROP_COUNT, 6-7 read 0)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    16-bit registered read data (1-cycle latency, always updated)
//   tick_irq    timer irq level; each rising edge is one tick
//   irq         CPU interrupt = drop_pending & ie
//   drop_pulse  one-cycle drop strobe to game logic
// -----------------------------------------------------------------------------
module labfinalsoc_gravity_tick #(
   parameter logic [15:0] LEVEL_PERIOD_RESET = 16'd50,
   parameter logic [15:0] SOFT_PERIOD_RESET  = 16'd5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   input  logic        tick_irq,
   output logic        irq,
   output logic        drop_pulse
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        irq_d_q;
   logic [15:0] tick_count_q, tick_count_d;
   logic [15:0] drop_count_q, drop_count_d;
   logic        drop_pending_q, drop_pending_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] level_period_q, level_period_d;
   logic [15:0] soft_period_q, soft_period_d;
   logic [15:0] readdata_q, readdata_d;
   logic        drop_pulse_q, drop_pulse_d;

   logic        wr_en;
   logic        wr_status, wr_ctrl, wr_level, wr_soft, wr_dropcnt, wr_period;
   logic        tick;
   logic [15:0] period_raw;
   logic [15:0] period_eff;
   logic [16:0] count_inc;
   logic        drop_event;

   // Decode, tick edge detect and drop decision
   always_comb begin
      wr_en      = chipselect & ~write_n;
      wr_status  = wr_en && (address == 3'd0);
      wr_ctrl    = wr_en && (address == 3'd1);
      wr_level   = wr_en && (address == 3'd2);
      wr_soft    = wr_en && (address == 3'd3);
      wr_dropcnt = wr_en && (address == 3'd5);
      wr_period  = wr_level | wr_soft;

      // A held-high tick_irq counts once: only the 0->1 transition is a tick.
      tick = tick_irq & ~irq_d_q;

      period_raw = ctrl_q[2] ? soft_period_q : level_period_q;
      period_eff = (period_raw == 16'd0) ? 16'd1 : period_raw;

      // 17-bit so a count of 0xFFFF cannot wrap past the period.
      count_inc = {1'b0, tick_count_q} + 17'd1;

      // A coincident period write resets the count and suppresses the drop.
      drop_event = (state_q == ST_RUN) && tick && !wr_period &&
                   (count_inc >= {1'b0, period_eff});
   end

   // FSM next state and register next values
   always_comb begin
      state_d        = state_q;
      tick_count_d   = tick_count_q;
      drop_count_d   = drop_count_q;
      drop_pending_d = drop_pending_q;
      ctrl_d         = ctrl_q;
      level_period_d = level_period_q;
      soft_period_d  = soft_period_q;
      drop_pulse_d   = drop_event;
      readdata_d     = 16'd0;

      if (wr_ctrl) begin
         ctrl_d  = writedata[2:0];
         state_d = writedata[1] ? ST_RUN : ST_IDLE;
      end

      if (wr_level) level_period_d = writedata;
      if (wr_soft)  soft_period_d  = writedata;

      // Tick counter: period write beats everything, then run/stop transition.
      if (wr_period) begin
         tick_count_d = 16'd0;
      end else if (state_d != state_q) begin
         tick_count_d = 16'd0;
      end else if (drop_event) begin
         tick_count_d = 16'd0;
      end else if ((state_q == ST_RUN) && tick) begin
         tick_count_d = count_inc[15:0];
      end

      // Setting the flag wins over a coincident STATUS write clear.
      if (drop_event) begin
         drop_pending_d = 1'b1;
      end else if (wr_status) begin
         drop_pending_d = 1'b0;
      end

      if (wr_dropcnt) begin
         drop_count_d = drop_event ? 16'd1 : 16'd0;
      end else if (drop_event) begin
         drop_count_d = drop_count_q + 16'd1;
      end

      case (address)
         3'd0:    readdata_d = {14'd0, (state_q == ST_RUN), drop_pending_q};
         3'd1:    readdata_d = {13'd0, ctrl_q};
         3'd2:    readdata_d = level_period_q;
         3'd3:    readdata_d = soft_period_q;
         3'd4:    readdata_d = tick_count_q;
         3'd5:    readdata_d = drop_count_q;
         default: readdata_d = 16'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         irq_d_q        <= 1'b0;
         tick_count_q   <= 16'd0;
         drop_count_q   <= 16'd0;
         drop_pending_q <= 1'b0;
         ctrl_q         <= 3'd0;
         level_period_q <= LEVEL_PERIOD_RESET;
         soft_period_q  <= SOFT_PERIOD_RESET;
         readdata_q     <= 16'd0;
         drop_pulse_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         irq_d_q        <= tick_irq;
         tick_count_q   <= tick_count_d;
         drop_count_q   <= drop_count_d;
         drop_pending_q <= drop_pending_d;
         ctrl_q         <= ctrl_d;
         level_period_q <= level_period_d;
         soft_period_q  <= soft_period_d;
         readdata_q     <= readdata_d;
         drop_pulse_q   <= drop_pulse_d;
      end
   end

   assign readdata   = readdata_q;
   assign drop_pulse = drop_pulse_q;
   assign irq        = drop_pending_q & ctrl_q[0];

endmodule
